gl_mac_scheduler: RTL and testbench
===================================

# gl_mac_scheduler

Time-multiplexed sequencer for the Grünwald–Letnikov fractional-order operator. It shares one signed multiplier and one accumulator across all WLENGTH weighting taps, and owns a circular history of past input samples. It runs one tap per cycle and emits y[n] = Σ coef[k]·x[n−k] through a valid/ready output. It sits between the sample source and downstream consumers, replacing the fully parallel GL datapath when area matters more than throughput.

## Interface
- WLENGTH, 128, number of GL taps and history depth (power of two, ≥4)
- FRAC, 24, coefficient fractional bits (Q7.24; 1.0 = 16777216)
- ACCW, 48, accumulator width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-low, clock clk
- in_valid  in  1  input sample valid
- in_ready  out  1  scheduler can accept a sample
- in_data  in  32  signed input sample x[n]
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(WLENGTH)  coefficient index k
- coef_wdata  in  32  signed coefficient value
- hist_clr  in  1  request history flush (sampled in IDLE only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  signed saturated y[n]
- busy  out  1  high in CLEAR, MAC, OUT
- sat  out  1  sticky: some result saturated since reset

## Operation
- States: CLEAR, IDLE, MAC, OUT.
- CLEAR: walks the history index 0..WLENGTH−1 and writes 0, one entry per cycle. Resets the write pointer wp to 0, then goes to IDLE.
- IDLE: in_ready=1.
  - in_valid&in_ready: writes in_data at hist[wp], clears acc, sets k=0, goes to MAC.
  - hist_clr with no in_valid: goes to CLEAR.
  - If both are high, the sample wins and hist_clr is ignored.
- MAC: each cycle computes acc += (coef[k]·hist[(wp−k) mod WLENGTH]) >>> FRAC.
  - The product is a 64-bit signed value. The arithmetic shift floors it. The result is sign-extended to ACCW.
  - k increments each cycle. After k=WLENGTH−1, wp increments (wraps mod WLENGTH) and the state goes to OUT.
- OUT: out_data = acc saturated to [−2^31, 2^31−1].
  - If saturation occurs, sat is set.
  - The state holds until out_ready, then returns to IDLE.
- Coefficient memory:
  - Write-only port, not cleared by reset.
  - coef_we is honoured in CLEAR, IDLE and OUT.
  - coef_we is silently ignored in MAC, so coefficients stay stable within one result.
- Accumulator overflow beyond ACCW is not detected. ACCW=48 is sufficient for 128 taps.

## Timing
- Reset (rst=0 at an edge): state→CLEAR, k=0, wp=0, acc=0.
  - Outputs: in_ready=0, out_valid=0, out_data=0, busy=1, sat=0.
- After rst releases, CLEAR lasts WLENGTH cycles. in_ready rises at the WLENGTH-th edge after release.
- A sample is accepted at edge E. MAC occupies cycles E+1..E+WLENGTH. out_valid rises after edge E+WLENGTH, so latency is WLENGTH cycles.
- out_valid and out_data are registered and stay stable while out_ready=0.
- The output handshake at edge F drops out_valid, and in_ready=1 after F.
- Best-case throughput is one sample per WLENGTH+2 cycles.
- in_ready is 0 in CLEAR, MAC and OUT. in_valid there is ignored (not queued).
- Reset mid-MAC or mid-OUT aborts the result:
  - out_valid=0 after the reset edge, with no partial output.
  - History is re-cleared; coefficients are preserved.
- hist_clr asserted outside IDLE is ignored.

## Test plan
- Reset/clear: rst=0 for 3 cycles, then 1. Required: all outputs at reset values, in_ready=0 for exactly 128 cycles after release, then 1.
- Impulse response: coef[0]=16777216, coef[1]=8388608, rest 0; send 1000, then 2000. Required: out_data=1000, then 2500, each exactly 128 cycles after acceptance.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid=1. Required: out_valid and out_data stable, in_ready=0, second sample accepted only after the output handshake.
- Saturation: all coef=16777216; send 0x7FFFFFFF twice. Required: second out_data=0x7FFFFFFF, sat=1. Then send −2^31 twice. Required: out_data=0x80000000.
- Wrap-around (WLENGTH=4): all coef=1.0; send 1,2,3,4,5,6. Required: outputs 1,3,6,10,14,18.
- Abort and coef lock: write coef[0]=0 during MAC, then reset mid-MAC. Required: no out_valid for the aborted sample, coef[0] unchanged, and the next sample x gives output coef[0]·x only (history zero).

Source files
------------

// File: rtl/gl_mac_scheduler_if.sv
// Sample, coefficient and result handshake bundle for gl_mac_scheduler.
// master drives samples/coefficients, slave is the scheduler.
interface gl_mac_scheduler_if #(
  parameter int unsigned WLENGTH = 128
) ();
  localparam int unsigned AW = $clog2(WLENGTH);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [31:0]   in_data;
  logic                 coef_we;
  logic        [AW-1:0] coef_addr;
  logic signed [31:0]   coef_wdata;
  logic                 hist_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [31:0]   out_data;
  logic                 busy;
  logic                 sat;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata, hist_clr, out_ready,
    input  in_ready, out_valid, out_data, busy, sat
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata, hist_clr, out_ready,
    output in_ready, out_valid, out_data, busy, sat
  );
endinterface

// File: rtl/gl_mac_scheduler.sv
// Time-multiplexed Grunwald-Letnikov MAC: one shared multiplier and accumulator,
// one tap per cycle over a circular sample history, valid/ready result output.
module gl_mac_scheduler #(
  parameter int unsigned WLENGTH = 128,
  parameter int unsigned FRAC    = 24,
  parameter int unsigned ACCW    = 48
) (
  input logic               clk,
  input logic               rst,
  gl_mac_scheduler_if.slave bus
);
  localparam int unsigned   AW    = $clog2(WLENGTH);
  localparam logic [AW-1:0] LastK = AW'(WLENGTH - 1);

  typedef enum logic [1:0] {StClear, StIdle, StMac, StOut} state_e;

  state_e                 state_q, state_d;
  logic        [AW-1:0]   k_q, k_d;
  logic        [AW-1:0]   wp_q, wp_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   out_valid_q, out_valid_d;
  logic signed [31:0]     out_data_q, out_data_d;
  logic                   sat_q, sat_d;

  logic signed [31:0] hist_q [WLENGTH];
  logic signed [31:0] coef_q [WLENGTH];

  logic               hist_we;
  logic [AW-1:0]      hist_waddr;
  logic signed [31:0] hist_wdata;

  logic        [AW-1:0]   tap_idx;
  logic signed [31:0]     coef_rd;
  logic signed [31:0]     hist_rd;
  logic signed [63:0]     prod;
  logic signed [ACCW-1:0] term;
  logic signed [ACCW-1:0] acc_sum;
  logic                   sat_pos;
  logic                   sat_neg;
  logic signed [31:0]     sat_val;

  // Tap k pairs with the sample k steps older than the newest one at wp.
  assign tap_idx = wp_q - k_q;
  assign coef_rd = coef_q[k_q];
  assign hist_rd = hist_q[tap_idx];
  assign prod    = 64'(coef_rd) * 64'(hist_rd);
  assign term    = ACCW'(prod >>> FRAC);
  assign acc_sum = acc_q + term;

  assign sat_pos = ~acc_sum[ACCW-1] & (|acc_sum[ACCW-2:31]);
  assign sat_neg = acc_sum[ACCW-1] & ~(&acc_sum[ACCW-2:31]);
  assign sat_val = sat_pos ? 32'sh7FFF_FFFF :
                   sat_neg ? 32'sh8000_0000 : acc_sum[31:0];

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wp_d        = wp_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    hist_we     = 1'b0;
    hist_waddr  = k_q;
    hist_wdata  = '0;

    unique case (state_q)
      StClear: begin
        hist_we    = 1'b1;
        hist_waddr = k_q;
        k_d        = k_q + 1'b1;
        if (k_q == LastK) begin
          wp_d    = '0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        // A sample takes priority over a flush request in the same cycle.
        if (bus.in_valid) begin
          hist_we    = 1'b1;
          hist_waddr = wp_q;
          hist_wdata = bus.in_data;
          acc_d      = '0;
          k_d        = '0;
          state_d    = StMac;
        end else if (bus.hist_clr) begin
          k_d     = '0;
          state_d = StClear;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == LastK) begin
          wp_d        = wp_q + 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = sat_val;
          if (sat_pos || sat_neg) begin
            sat_d = 1'b1;
          end
          state_d = StOut;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StClear;
      k_q         <= '0;
      wp_q        <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wp_q        <= wp_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && hist_we) begin
      hist_q[hist_waddr] <= hist_wdata;
    end
  end

  // Coefficients survive reset and are frozen while a result is being summed.
  always_ff @(posedge clk) begin
    if (rst && bus.coef_we && (state_q != StMac)) begin
      coef_q[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_gl_mac_scheduler.sv
// Randomised bench for gl_mac_scheduler against a queue-based GL sum model,
// plus directed reset, impulse, backpressure, saturation, abort and wrap cases.
module tb_gl_mac_scheduler;
  localparam int unsigned W    = 128;
  localparam int unsigned W4   = 4;
  localparam int unsigned FRAC = 24;
  localparam longint      SMax = 64'sd2147483647;
  localparam longint      SMin = -64'sd2147483648;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst4 = 1'b0;

  always #5 clk = ~clk;

  gl_mac_scheduler_if #(.WLENGTH(W))  bus ();
  gl_mac_scheduler_if #(.WLENGTH(W4)) bus4 ();

  gl_mac_scheduler #(.WLENGTH(W), .FRAC(FRAC), .ACCW(48)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gl_mac_scheduler #(.WLENGTH(W4), .FRAC(FRAC), .ACCW(48)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: coefficients, samples newest-first since last flush, sticky sat.
  int coef_m [W];
  int hist_m [$];
  bit sat_m = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_acc();
    longint acc = 0;
    for (int k = 0; k < W; k++) begin
      if (k < hist_m.size()) acc += (longint'(coef_m[k]) * longint'(hist_m[k])) >>> FRAC;
    end
    return acc;
  endfunction

  task automatic write_coef(input int k, input int v);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 7'(k);
    bus.coef_wdata = v;
    tick();
    bus.coef_we = 1'b0;
    coef_m[k]   = v;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check_val({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_result(input string tag, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 1000) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) check_val({tag, "_result_timeout"}, 0, 1);
  endtask

  task automatic send_check(input string tag, input int x, input bit hclr, output longint y);
    int     lat;
    longint exp;
    wait_ready(tag);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.hist_clr = hclr;
    tick();
    bus.in_valid = 1'b0;
    bus.hist_clr = 1'b0;
    hist_m.push_front(x);
    if (hist_m.size() > W) void'(hist_m.pop_back());
    wait_result(tag, lat);
    y   = longint'(bus.out_data);
    exp = model_acc();
    if (exp > SMax) begin
      exp   = SMax;
      sat_m = 1'b1;
    end else if (exp < SMin) begin
      exp   = SMin;
      sat_m = 1'b1;
    end
    check_val({tag, "_y"}, y, exp);
    check_val({tag, "_lat"}, lat, W);
    check_val({tag, "_sat"}, bus.sat, sat_m);
  endtask

  task automatic handshake(input string tag, input int delay, input longint held);
    repeat (delay) begin
      tick();
      check_val({tag, "_hold_valid"}, bus.out_valid, 1);
      check_val({tag, "_hold_data"}, longint'(bus.out_data), held);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_val({tag, "_hs_valid"}, bus.out_valid, 0);
    check_val({tag, "_hs_ready"}, bus.in_ready, 1);
  endtask

  task automatic do_sample(input string tag, input int x, input bit hclr, output longint y);
    send_check(tag, x, hclr, y);
    handshake(tag, int'($urandom_range(3, 0)), y);
  endtask

  task automatic hist_flush(input string tag);
    wait_ready(tag);
    bus.hist_clr = 1'b1;
    tick();
    bus.hist_clr = 1'b0;
    hist_m.delete();
    check_val({tag, "_busy"}, bus.busy, 1);
  endtask

  task automatic count_clear(input string tag);
    int n       = 0;
    int ov_seen = 0;
    do begin
      tick();
      n++;
      if (bus.out_valid) ov_seen++;
    end while (!bus.in_ready && n < 1000);
    check_val({tag, "_len"}, n, W);
    check_val({tag, "_no_valid"}, ov_seen, 0);
  endtask

  initial begin
    longint y;
    int     lat;
    int     exp4 [6];
    exp4 = '{1, 3, 6, 10, 14, 18};

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    bus.hist_clr   = 1'b0;
    bus.out_ready  = 1'b0;
    bus4.in_valid   = 1'b0;
    bus4.in_data    = '0;
    bus4.coef_we    = 1'b0;
    bus4.coef_addr  = '0;
    bus4.coef_wdata = '0;
    bus4.hist_clr   = 1'b0;
    bus4.out_ready  = 1'b0;

    // Reset and clear walk.
    repeat (3) tick();
    check_val("rst_in_ready", bus.in_ready, 0);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", longint'(bus.out_data), 0);
    check_val("rst_busy", bus.busy, 1);
    check_val("rst_sat", bus.sat, 0);
    rst = 1'b1;
    count_clear("clear0");
    check_val("idle_busy", bus.busy, 0);

    // Impulse response.
    for (int k = 0; k < W; k++) write_coef(k, 0);
    write_coef(0, 16777216);
    write_coef(1, 8388608);
    do_sample("imp0", 1000, 1'b0, y);
    check_val("imp0_const", y, 1000);
    do_sample("imp1", 2000, 1'b0, y);
    check_val("imp1_const", y, 2500);

    // Backpressure with a sample waiting on in_valid.
    send_check("bp0", 3000, 1'b0, y);
    bus.in_valid = 1'b1;
    bus.in_data  = 4000;
    repeat (20) begin
      tick();
      check_val("bp_valid", bus.out_valid, 1);
      check_val("bp_data", longint'(bus.out_data), y);
      check_val("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_val("bp_hs_valid", bus.out_valid, 0);
    check_val("bp_hs_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check_val("bp_accepted", bus.in_ready, 0);
    hist_m.push_front(4000);
    wait_result("bp1", lat);
    check_val("bp1_lat", lat, W);
    check_val("bp1_y", longint'(bus.out_data), model_acc());
    handshake("bp1", 0, longint'(bus.out_data));

    // Saturation; coefficient writes overlap the CLEAR walk.
    hist_flush("satp_clr");
    for (int k = 0; k < W; k++) write_coef(k, 16777216);
    do_sample("satp0", 32'h7FFF_FFFF, 1'b0, y);
    check_val("satp0_const", y, SMax);
    do_sample("satp1", 32'h7FFF_FFFF, 1'b0, y);
    check_val("satp1_const", y, SMax);
    check_val("satp1_flag", bus.sat, 1);
    hist_flush("satn_clr");
    do_sample("satn0", 32'h8000_0000, 1'b0, y);
    do_sample("satn1", 32'h8000_0000, 1'b0, y);
    check_val("satn1_const", y, SMin);

    // Randomised coefficients, samples, flushes and flush/sample collisions.
    for (int k = 0; k < W; k++) write_coef(k, int'($urandom_range(33554432, 0)) - 16777216);
    for (int i = 0; i < 14; i++) begin
      int r = int'($urandom_range(99, 0));
      if (r < 25) begin
        for (int j = 0; j < 4; j++) begin
          write_coef(int'($urandom_range(W - 1, 0)), int'($urandom_range(33554432, 0)) - 16777216);
        end
      end else if (r < 45) begin
        hist_flush("rnd_clr");
      end
      do_sample("rnd", int'($urandom_range(2097152, 0)) - 1048576, (r >= 85), y);
    end

    // Reset while a result is held in OUT.
    send_check("rout", 777777, 1'b0, y);
    rst = 1'b0;
    tick();
    check_val("rout_valid", bus.out_valid, 0);
    check_val("rout_data", longint'(bus.out_data), 0);
    rst   = 1'b1;
    sat_m = 1'b0;
    hist_m.delete();
    count_clear("clear1");

    // Reset mid-MAC; the coefficient write inside MAC must be dropped.
    write_coef(0, 12582912);
    wait_ready("abort");
    bus.in_valid = 1'b1;
    bus.in_data  = 123456;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    bus.coef_we    = 1'b1;
    bus.coef_addr  = '0;
    bus.coef_wdata = 0;
    tick();
    bus.coef_we = 1'b0;
    repeat (10) tick();
    check_val("abort_mac_valid", bus.out_valid, 0);
    rst = 1'b0;
    tick();
    check_val("abort_rst_valid", bus.out_valid, 0);
    check_val("abort_rst_ready", bus.in_ready, 0);
    rst = 1'b1;
    hist_m.delete();
    count_clear("clear2");
    do_sample("post_abort", 1000000, 1'b0, y);
    check_val("post_abort_const", y, 750000);

    // Small instance: history wrap-around with all-ones coefficients.
    rst4 = 1'b1;
    lat  = 0;
    while (!bus4.in_ready && lat < 100) begin
      tick();
      lat++;
    end
    check_val("w4_clear_len", lat, W4);
    for (int k = 0; k < W4; k++) begin
      bus4.coef_we    = 1'b1;
      bus4.coef_addr  = 2'(k);
      bus4.coef_wdata = 16777216;
      tick();
    end
    bus4.coef_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      while (!bus4.in_ready && n < 100) begin
        tick();
        n++;
      end
      bus4.in_valid = 1'b1;
      bus4.in_data  = i + 1;
      tick();
      bus4.in_valid = 1'b0;
      lat = 0;
      while (!bus4.out_valid && lat < 100) begin
        tick();
        lat++;
      end
      check_val("w4_lat", lat, W4);
      check_val($sformatf("w4_y%0d", i), longint'(bus4.out_data), exp4[i]);
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
